bcd_to_bin: RTL and testbench

Sequential converter that accepts a packed multi-digit BCD value and returns its binary equivalent. It reads back the digit vectors produced by the team's BCD counter chains, so downstream arithmetic and compare logic can work in binary. Conversion is iterative reverse double-dabble: one shift per clock, under a start/busy/done handshake.

---
 rtl/bcd_to_bin.sv | 127 ++++++++++++
 tb/tb_bcd_to_bin.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: iterative BCD-to-binary converter (reverse double-dabble).
//
// A packed DIGITS-digit BCD operand is accepted on a start request while
// idle and converted one shift per clock. Operands containing a digit above
// 9 are rejected without converting and flagged through err.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous, active-low reset
//   start    conversion request, sampled only while idle
//   bcd_in   packed BCD operand, digit 0 at bcd_in[3:0]
//   busy     high while a conversion is shifting
//   done     one-cycle pulse when bin_out/err are updated
//   bin_out  binary result, held until the next accepted start
//   err      last accepted operand held an invalid digit
module bcd_to_bin #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7    // 2^BIN_W must exceed 10^DIGITS - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t                state;
  logic [4*DIGITS-1:0]   dig_q;
  logic [BIN_W-1:0]      bin_q;
  logic [CNT_W-1:0]      count;

  logic                  bad_digit;
  logic [4*DIGITS-1:0]   dig_next;
  logic [BIN_W-1:0]      bin_next;

  // One reverse double-dabble step: shift {digits, binary} right by one,
  // then pull every digit that landed at 8 or above back by 3. Each digit
  // is corrected on its own; no carry crosses a digit boundary.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    bad_digit = 1'b0;
    dig_next  = dig_q >> 1;
    bin_next  = {dig_q[0], bin_q[BIN_W-1:1]};
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) begin
        bad_digit = 1'b1;
      end
      if (dig_next[4*i +: 4] >= 4'd8) begin
        dig_next[4*i +: 4] = dig_next[4*i +: 4] - 4'd3;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      dig_q   <= '0;
      bin_q   <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (bad_digit) begin
              // Rejected operand: skip straight to the done pulse.
              bin_out <= '0;
              err     <= 1'b1;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              dig_q <= bcd_in;
              bin_q <= '0;
              count <= '0;
              busy  <= 1'b1;
              state <= CONV;
            end
          end
        end

        CONV: begin
          dig_q <= dig_next;
          bin_q <= bin_next;
          count <= count + 1'b1;
          if (count == LAST_STEP) begin
            // The final step's shifted value goes straight to the output.
            bin_out <= bin_next;
            err     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin (DIGITS=2, BIN_W=7).
module tb_bcd_to_bin;

  localparam int DIGITS = 2;
  localparam int BIN_W  = 7;

  logic             clk;
  logic             reset;
  logic             start;
  logic [7:0]       bcd_in;
  logic             busy;
  logic             done;
  logic [BIN_W-1:0] bin_out;
  logic             err;

  int errors = 0;
  int checks = 0;

  bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bcd;
    int         exp_bin;
    bit         exp_err;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reference: decimal weight of each nibble, rejecting any nibble above 9.
  function automatic void model(input logic [7:0] v, output int val, output bit bad);
    int d;
    val = 0;
    bad = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = int'((v >> (4 * i)) & 8'h0f);
      if (d > 9) bad = 1'b1;
      val = val * 10 + d;
    end
    if (bad) val = 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1 with the DUT idle. Drives start for one cycle, then
  // scrambles bcd_in and optionally pokes start again at CONV cycle 'poke'.
  // Returns at the earliest cycle a new start may be accepted.
  task automatic convert(input logic [7:0] v, input int exp_bin, input bit exp_err,
                         input int poke, input string name);
    int n;
    int nbusy;
    int exp_lat;
    start  = 1'b1;
    bcd_in = v;
    step();
    start  = 1'b0;
    bcd_in = 8'($urandom);
    n = 0;
    nbusy = 0;
    while (!done && n < 40) begin
      if (busy) nbusy++;
      if (n == poke) begin
        start  = 1'b1;
        bcd_in = 8'h12;
      end else begin
        start = 1'b0;
      end
      step();
      n++;
    end
    start = 1'b0;
    exp_lat = exp_err ? 0 : BIN_W;
    check({name, " done_seen"}, int'(done), 1);
    check({name, " latency"}, n, exp_lat);
    check({name, " busy_cycles"}, nbusy, exp_lat);
    check({name, " busy_with_done"}, int'(busy), 0);
    check({name, " bin_out"}, int'(bin_out), exp_bin);
    check({name, " err"}, int'(err), int'(exp_err));
    step();
    check({name, " done_one_cycle"}, int'(done), 0);
  endtask

  vec_t vecs[$];

  initial begin
    int   val;
    bit   bad;
    logic [7:0] r;
    bit   saw;

    vecs.push_back('{8'h99, 99, 1'b0});
    vecs.push_back('{8'h00,  0, 1'b0});
    vecs.push_back('{8'h47, 47, 1'b0});
    vecs.push_back('{8'h10, 10, 1'b0});
    vecs.push_back('{8'hA5,  0, 1'b1});
    vecs.push_back('{8'h05,  5, 1'b0});
    vecs.push_back('{8'h3F,  0, 1'b1});
    vecs.push_back('{8'h90, 90, 1'b0});
    vecs.push_back('{8'hFF,  0, 1'b1});
    vecs.push_back('{8'h80, 80, 1'b0});

    reset  = 1'b0;
    start  = 1'b0;
    bcd_in = 8'h00;
    repeat (3) step();
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset bin_out", int'(bin_out), 0);
    check("reset err", int'(err), 0);
    reset = 1'b1;
    step();

    // Table vectors, back to back at the earliest accept.
    foreach (vecs[i]) begin
      convert(vecs[i].bcd, vecs[i].exp_bin, vecs[i].exp_err, -1,
              $sformatf("vec%0d_%02h", i, vecs[i].bcd));
    end

    // Start pulsed mid-conversion with a new operand: must be ignored.
    convert(8'h63, 63, 1'b0, 2, "ignore_start");
    saw = 1'b0;
    repeat (12) begin
      if (busy || done) saw = 1'b1;
      step();
    end
    check("ignore_start no_requeue", int'(saw), 0);
    check("ignore_start held", int'(bin_out), 63);

    // Reset during the 4th CONV cycle aborts with no done pulse.
    start  = 1'b1;
    bcd_in = 8'h88;
    step();
    start  = 1'b0;
    repeat (3) step();
    check("abort busy_before", int'(busy), 1);
    reset = 1'b0;
    #1;
    check("abort busy", int'(busy), 0);
    check("abort bin_out", int'(bin_out), 0);
    check("abort err", int'(err), 0);
    step();
    reset = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      if (busy || done) saw = 1'b1;
      step();
    end
    check("abort no_done", int'(saw), 0);
    convert(8'h31, 31, 1'b0, -1, "after_abort");

    // Full sweep of valid operands.
    for (int i = 0; i < 100; i++) begin
      r = 8'(((i / 10) << 4) | (i % 10));
      model(r, val, bad);
      check($sformatf("sweep_model %0d", i), val, i);
      convert(r, i, 1'b0, -1, $sformatf("sweep%0d", i));
    end

    // Random operands, valid and invalid, against the arithmetic model.
    repeat (40) begin
      r = 8'($urandom_range(0, 255));
      model(r, val, bad);
      convert(r, val, bad, -1, $sformatf("rand_%02h", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
